// File: rtl/shift_sequencer_if.sv
// Bundles the request handshake and the barrel-shifter connection of shift_sequencer.
// The sequencer uses the slave modport; the requester/shifter environment uses master.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [5:0]  amt;
  logic [31:0] a_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
  logic [4:0]  sh_sh;
  logic        sh_s;
  logic [31:0] sh_a;
  logic [31:0] sh_aout;
  logic        sh_lco;
  logic        sh_rco;

  modport slave (
    input  start, op, amt, a_in, sh_aout, sh_lco, sh_rco,
    output busy, done, result, carry, sh_sh, sh_s, sh_a
  );

  modport master (
    output start, op, amt, a_in, sh_aout, sh_lco, sh_rco,
    input  busy, done, result, carry, sh_sh, sh_s, sh_a
  );
endinterface

// File: rtl/shift_sequencer.sv
// Drives an external 32-bit combinational barrel shifter for one or two 5-bit passes
// to perform LSL/LSR/ROR/ROL by 0-63, registering the final result and carry.
module shift_sequencer (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd2;
  localparam logic [1:0] OP_ROL = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic [5:0]  r_amt;
  logic [31:0] r_a;
  logic [31:0] r_temp;
  logic [31:0] r_result;
  logic        r_carry;

  logic        w_isRotate;
  logic [4:0]  w_k;
  logic        w_twoPass;
  logic        w_rightPass1;
  logic [4:0]  w_pass1Sh;
  logic [4:0]  w_pass2Sh;
  logic [4:0]  w_shSh;
  logic        w_shS;
  logic [31:0] w_shA;
  logic [31:0] w_finalResult;
  logic        w_finalCarry;

  assign w_isRotate   = r_op[1];
  assign w_k          = r_amt[4:0];
  assign w_twoPass    = w_isRotate ? (w_k != 5'd0) : r_amt[5];
  assign w_rightPass1 = (r_op == OP_LSR) || (r_op == OP_ROR);
  assign w_pass1Sh    = (!w_isRotate && r_amt[5]) ? 5'd31 : w_k;

  // Long shifts: amt-31 equals amt[4:0]+1; amt=63 would need 32, so it is clamped to 31
  // (the operand is already down to a single bit, so the carry and result stay 0).
  always_comb begin
    w_pass2Sh = 5'd0 - w_k;
    if (!w_isRotate) begin
      w_pass2Sh = (w_k == 5'd31) ? 5'd31 : w_k + 5'd1;
    end
  end

  always_comb begin
    w_shSh = 5'd0;
    w_shS  = 1'b0;
    w_shA  = 32'd0;
    case (r_state)
      S_PASS1: begin
        w_shSh = w_pass1Sh;
        w_shS  = w_rightPass1;
        w_shA  = r_a;
      end
      S_PASS2: begin
        w_shSh = w_pass2Sh;
        w_shS  = w_isRotate ? ~w_rightPass1 : w_rightPass1;
        w_shA  = w_isRotate ? r_a : r_temp;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_finalResult = bus.sh_aout;
    if (w_isRotate && (r_state == S_PASS2)) begin
      w_finalResult = r_temp | bus.sh_aout;
    end else if (!w_isRotate && r_amt[5]) begin
      w_finalResult = 32'd0;
    end
    case (r_op)
      OP_LSL:  w_finalCarry = (r_amt == 6'd0) ? 1'b0 : bus.sh_lco;
      OP_LSR:  w_finalCarry = (r_amt == 6'd0) ? 1'b0 : bus.sh_rco;
      OP_ROR:  w_finalCarry = w_finalResult[31];
      default: w_finalCarry = w_finalResult[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_amt    <= 6'd0;
      r_a      <= 32'd0;
      r_temp   <= 32'd0;
      r_result <= 32'd0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_amt   <= bus.amt;
            r_a     <= bus.a_in;
            r_state <= S_PASS1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PASS1: begin
          r_temp <= bus.sh_aout;
          if (w_twoPass) begin
            r_state <= S_PASS2;
          end else begin
            r_result <= w_finalResult;
            r_carry  <= w_finalCarry;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_result <= w_finalResult;
          r_carry  <= w_finalCarry;
          r_state  <= S_DONE;
        end
      endcase
    end
  end

  assign bus.busy   = (r_state == S_PASS1) || (r_state == S_PASS2);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.carry  = r_carry;
  assign bus.sh_sh  = w_shSh;
  assign bus.sh_s   = w_shS;
  assign bus.sh_a   = w_shA;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle control stage that sits directly upstream of the 32-bit barrel shifter and consumes its result in the same datapath slice. It accepts a shift or rotate request with a 6-bit amount (0–63) and drives the combinational shifter for one or two passes. Rotates and shifts of 32 or more are decomposed into legal 5-bit shifter passes. It registers the final 32-bit result and carry flag and signals completion with a one-cycle `done` pulse.

## Interface
Parameters: none; the width is fixed at 32 to match the shifter.

Clock and reset:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.

Request side:
- `start` in 1: request strobe; accepted only when `busy`=0.
- `op` in 2: operation; 00 LSL, 01 LSR, 10 ROR, 11 ROL.
- `amt` in 6: shift amount, 0–63.
- `a_in` in 32: operand.
- `busy` out 1: high while a pass is in progress.
- `done` out 1: one-cycle pulse; `result` and `carry` are valid from this cycle on.
- `result` out 32: registered result.
- `carry` out 1: registered carry flag.

Shifter side:
- `sh_sh` out 5: drives shifter amount.
- `sh_s` out 1: direction; 1 = right, 0 = left.
- `sh_a` out 32: shifter operand.
- `sh_aout` in 32: shifter result.
- `sh_lco` in 1: last bit shifted out on the left.
- `sh_rco` in 1: last bit shifted out on the right.

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE or DONE with `start`=1: latch `op`, `amt`, `a_in` into internal registers and go to PASS1. In DONE this gives back-to-back operation.
- Inputs after acceptance are don't-care; `start` while `busy`=1 is ignored.
- The shifter is combinational. In PASS1/PASS2 the block drives `sh_*` from registers and captures `sh_aout`/`sh_lco`/`sh_rco` at the end of that cycle.
- In IDLE and DONE, `sh_sh`, `sh_s` and `sh_a` are driven to 0.

Per-operation behaviour (k = `amt` mod 32):
- LSL or LSR with `amt` ≤ 31: single pass, SH=`amt`.
  - `carry` = `sh_lco` for LSL, `sh_rco` for LSR.
  - `amt`=0 gives `result`=A, `carry`=0.
- LSL or LSR with `amt` 32–63: two passes.
  - PASS1 uses SH=31 on A; PASS2 uses SH=`amt`−31 on the PASS1 result.
  - `carry` is taken from PASS2: A[0] for LSL 32, A[31] for LSR 32, and 0 for `amt` > 32.
  - `result` = 0.
- ROR or ROL with k = 0: single pass, SH=0; `result`=A.
- ROR with k ≠ 0: two passes.
  - PASS1: A right by k, stored in temp.
  - PASS2: A left by 32−k (always ≤ 31).
  - `result` = temp | PASS2 output.
- ROL with k ≠ 0: mirror of ROR.
  - PASS1: A left by k, stored in temp.
  - PASS2: A right by 32−k.
  - `result` = temp | PASS2 output.
- Rotate carry: `carry` = `result`[31] for ROR and `result`[0] for ROL, including the k = 0 case.
- `result` and `carry` update only on the edge that finishes the last pass. They hold until the next completion.

## Timing
- Reset values: state IDLE; `busy`, `done`, `carry` = 0; `result` = 0; `sh_*` = 0.
- Latency is counted from edge E0, the edge that samples `start`=1.
  - Single-pass: PASS1 in cycle E0–E1; `done`=1 in cycle E1–E2.
  - Two-pass: PASS1, then PASS2; `done`=1 in cycle E2–E3.
- `busy` = 1 exactly in PASS1 and PASS2; it is 0 in IDLE and DONE.
- DONE lasts one cycle. It then moves to IDLE, or to PASS1 if `start`=1.
- Throughput: a new operation every 2 cycles for single-pass ops, every 3 cycles for two-pass ops.
- `rst` in any state (mid-operation included): next cycle is IDLE with all outputs at reset values. No `done` is issued for the aborted operation.

## Test plan
- Single-pass LSL: LSL 4, A=0x1800_0001 → `done` at E1, `result`=0x8000_0010, `carry`=1. Then LSR 1, A=0x0000_0003 → `result`=0x0000_0001, `carry`=1.
- Long LSL: LSL 32, A=0x0000_0001 → two passes, `done` at E2, `result`=0, `carry`=1. LSL 40 of 0xFFFF_FFFF → `result`=0, `carry`=0.
- Rotates: ROR 8, A=0x1234_5678 → `result`=0x7812_3456, `carry`=0. ROR 40 gives the same. ROL 4, A=0x8000_0001 → `result`=0x0000_0018, `carry`=0.
- Zero amounts: LSL 0 and ROR 32, A=0xDEAD_BEEF → `result`=0xDEAD_BEEF, single pass. LSL `carry`=0; ROR `carry`=1.
- Handshake: `start` pulsed during PASS1 is ignored (`a_in` changed meanwhile; result uses the latched A). `start` during DONE is accepted, and `busy` rises the next cycle.
- Reset: assert `rst` during PASS2 of a ROR → next cycle IDLE, `result`=0, `carry`=0, no `done`. A following LSR 1 of 0x2 gives `result`=0x1.
